// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer that runs WIDTH-bit ALU operations
// through a single external 1-bit ALU slice, LSB first.
//
// The slice is purely combinational. Each RUN cycle this block presents one
// operand bit pair plus the running carry, and the slice returns one result
// bit and one carry bit in the same cycle. The clock edge then captures both.
// An operation is accepted on a valid/ready handshake. The assembled result
// is returned on a second valid/ready handshake. At least one IDLE cycle
// separates two operations, so throughput is one operation per WIDTH+2
// cycles.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  // operation request
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_mode,
  input  logic [2:0]       op_sel,
  // slice interface
  output logic             alu_op1,
  output logic             alu_op2,
  output logic             alu_mode,
  output logic [2:0]       alu_opsel,
  output logic             alu_cin,
  input  logic             alu_result,
  input  logic             alu_cout,
  // result return
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_cout,
  output logic             res_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;      // operand A shift register
  logic [WIDTH-1:0]   sb_q, sb_d;      // operand B shift register
  logic [WIDTH-1:0]   res_q, res_d;    // result shift register, filled MSB-first
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [2:0]         sel_q, sel_d;

  logic               cin0;
  logic               accept;

  // Initial carry. The subtract, increment and A+~B+1 codes need a carry-in
  // of 1. Pass-A and every logic code need 0. For the logic shift the
  // carry-in is the bit shifted into the LSB.
  assign cin0   = ~op_mode & ~op_sel[2] & (op_sel[1] | op_sel[0]);
  assign accept = (state_q == IDLE) & start_valid;

  // State and datapath registers; reset clears everything asynchronously.
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register here is a plain flop with no memory array, so all of them can
  // take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      sel_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sel_q   <= sel_q == sel_d ? sel_q : sel_d;
    end
  end

  // Next-state and datapath update: latch on accept, then shift once per RUN cycle.
  // NOTE: every _d signal gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sel_d   = sel_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sa_d    = op_a;
          sb_d    = op_b;
          mode_d  = op_mode;
          sel_d   = op_sel;
          carry_d = cin0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The slice answer for the current bit pair is captured on this edge.
        res_d   = {alu_result, res_q[WIDTH-1:1]};
        carry_d = alu_cout;
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The result stays frozen until the consumer takes it. The next
        // accept is only possible from IDLE.
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slice drive: active only in RUN, forced to zero otherwise.
  always_comb begin
    alu_op1   = 1'b0;
    alu_op2   = 1'b0;
    alu_mode  = 1'b0;
    alu_opsel = 3'b000;
    alu_cin   = 1'b0;
    if (state_q == RUN) begin
      alu_op1   = sa_q[0];
      alu_op2   = sb_q[0];
      alu_mode  = mode_q;
      alu_opsel = sel_q;
      alu_cin   = carry_q;
    end
  end

  // Handshake and result outputs: the result port is only meaningful in DONE.
  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    result      = '0;
    res_cout    = 1'b0;
    res_zero    = 1'b0;
    if (state_q == DONE) begin
      result   = res_q;
      res_cout = carry_q;
      res_zero = (res_q == '0);
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq. A bit-level model of the 1-bit slice closes
// the loop around the DUT. Results are compared against a word-level
// reference model.
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_mode;
  logic [2:0]       op_sel;
  logic             alu_op1;
  logic             alu_op2;
  logic             alu_mode;
  logic [2:0]       alu_opsel;
  logic             alu_cin;
  logic             alu_result;
  logic             alu_cout;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             res_cout;
  logic             res_zero;

  int checks = 0;
  int errors = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_mode     (op_mode),
    .op_sel      (op_sel),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_mode    (alu_mode),
    .alu_opsel   (alu_opsel),
    .alu_cin     (alu_cin),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .res_cout    (res_cout),
    .res_zero    (res_zero)
  );

  always #5 clk = ~clk;

  // 1-bit slice model: a combinational response to the sequencer's drive.
  always_comb begin
    logic [1:0] s;
    s          = 2'b00;
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    if (!alu_mode) begin
      if (alu_opsel[2]) begin
        alu_result = alu_op1;
      end else begin
        case (alu_opsel[1:0])
          2'b00:   s = {1'b0, alu_op1} + {1'b0, alu_op2}  + {1'b0, alu_cin};
          2'b10:   s = {1'b0, alu_op1} + {1'b0, alu_cin};
          default: s = {1'b0, alu_op1} + {1'b0, ~alu_op2} + {1'b0, alu_cin};
        endcase
        alu_result = s[0];
        alu_cout   = s[1];
      end
    end else begin
      if (alu_opsel[2]) begin
        alu_result = alu_cin;
        alu_cout   = alu_op1;
      end else begin
        case (alu_opsel[1:0])
          2'b00:   alu_result = alu_op1 & alu_op2;
          2'b01:   alu_result = alu_op1 | alu_op2;
          2'b10:   alu_result = alu_op1 ^ alu_op2;
          default: alu_result = ~alu_op1;
        endcase
      end
    end
  end

  // Word-level reference for a whole operation.
  function automatic void ref_model(input logic m, input logic [2:0] s,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] r,
                                    output logic c);
    logic [WIDTH:0] sum;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    if (!m) begin
      if (s[2]) begin
        r = a;
      end else begin
        case (s[1:0])
          2'b00:   sum = {1'b0, a} + {1'b0, b};
          2'b10:   sum = {1'b0, a} + 1;
          default: sum = {1'b0, a} + {1'b0, ~b} + 1;
        endcase
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
    end else begin
      if (s[2]) begin
        r = a << 1;
        c = a[WIDTH-1];
      end else begin
        case (s[1:0])
          2'b00:   r = a & b;
          2'b01:   r = a | b;
          2'b10:   r = a ^ b;
          default: r = ~a;
        endcase
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one operation. Called at a point #1 after an edge with the DUT in IDLE.
  task automatic run_op(input logic m, input logic [2:0] s,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold,
                        output logic [WIDTH-1:0] r, output logic c,
                        output logic z, output int lat);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    op_mode     = m;
    op_sel      = s;
    check("start_ready in idle", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    // Scramble operands after acceptance; they must have no effect.
    op_a    = WIDTH'($urandom);
    op_b    = WIDTH'($urandom);
    op_mode = 1'($urandom);
    op_sel  = 3'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!res_valid && lat < 4 * WIDTH);
    r = result;
    c = res_cout;
    z = res_zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold result stable", {res_valid, res_cout, result}, {1'b1, c, r});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid drops after handshake", res_valid, 0);
  endtask

  typedef struct {
    logic             m;
    logic [2:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             z;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [WIDTH-1:0] r, er;
    logic             c, ec, z;
    int               lat;

    vecs[0] = '{1'b0, 3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'b001, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 3'b001, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3'b010, 8'hFF, 8'h5C, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 3'b010, 8'hF0, 8'hAA, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'b100, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 3'b011, 8'h0F, 8'h55, 8'hF0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 3'b110, 8'h77, 8'h99, 8'h77, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 3'b011, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0};

    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    op_mode     = 1'b0;
    op_sel      = 3'b000;
    #2;
    check("reset start_ready", start_ready, 1);
    check("reset res_valid/cout/zero", {res_valid, res_cout, res_zero}, 0);
    check("reset result", result, 0);
    check("reset alu outputs", {alu_op1, alu_op2, alu_mode, alu_opsel, alu_cin}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b, 0, r, c, z, lat);
      check($sformatf("vec%0d latency", i), lat, WIDTH);
      check($sformatf("vec%0d result", i), r, vecs[i].r);
      check($sformatf("vec%0d cout", i), c, vecs[i].c);
      check($sformatf("vec%0d zero", i), z, vecs[i].z);
    end

    // Back-pressure: DONE held for 5 cycles with a new request pending.
    run_op(1'b0, 3'b000, 8'h11, 8'h22, 0, r, c, z, lat);
    start_valid = 1'b1;
    op_a        = 8'h11;
    op_b        = 8'h22;
    op_mode     = 1'b0;
    op_sel      = 3'b000;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (WIDTH) @(posedge clk);
    #1;
    check("bp result valid", {res_valid, res_cout, result}, {1'b1, 1'b0, 8'h33});
    start_valid = 1'b1;
    op_a        = 8'h05;
    op_b        = 8'h03;
    op_sel      = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp stable", {start_ready, res_valid, res_cout, result}, {1'b0, 1'b1, 1'b0, 8'h33});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp idle cycle", {start_ready, res_valid}, 2'b10);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("bp new op accepted", start_ready, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!res_valid && lat < 4 * WIDTH);
    check("bp new op latency", lat, WIDTH);
    check("bp new op result", {res_cout, result}, {1'b1, 8'h02});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Asynchronous reset after the third RUN edge.
    start_valid = 1'b1;
    op_a        = 8'hFF;
    op_b        = 8'h00;
    op_mode     = 1'b0;
    op_sel      = 3'b011;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-run alu_opsel", alu_opsel, 3'b011);
    rst = 1'b1;
    #1;
    check("async rst res_valid/start_ready", {res_valid, start_ready}, 2'b01);
    check("async rst alu outputs", {alu_op1, alu_op2, alu_mode, alu_opsel, alu_cin}, 0);
    check("async rst result", result, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 3'b000, 8'h01, 8'h01, 0, r, c, z, lat);
    check("post-reset latency", lat, WIDTH);
    check("post-reset add", {c, z, r}, {1'b0, 1'b0, 8'h02});

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic             m;
      logic [2:0]       s;
      logic [WIDTH-1:0] a, b;
      m = 1'($urandom);
      s = 3'($urandom);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      ref_model(m, s, a, b, er, ec);
      run_op(m, s, a, b, int'($urandom_range(0, 2)), r, c, z, lat);
      check($sformatf("rand%0d latency", i), lat, WIDTH);
      check($sformatf("rand%0d m%0d s%0d a%0h b%0h result", i, m, s, a, b), r, er);
      check($sformatf("rand%0d cout", i), c, ec);
      check($sformatf("rand%0d zero", i), z, (er == '0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
